// File: rtl/alu_instr_sequencer_if.sv
// Sequencer <-> datapath/memory bundle for the ezRISC ALU-instruction sequencer.
// Latency: none (wires only). Backpressure: memory stalls via mem_rdy, sampled by the sequencer in T1.
// Ports: run/ir/mem_rdy flow into the sequencer; strobes, alu_op, gpr selects, done, halted flow out.
//   master modport = sequencer side, slave modport = datapath/memory side.
interface alu_instr_sequencer_if;
  // Inputs to the sequencer
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;

  // Datapath strobes
  logic        pc_out;
  logic        inc_pc;
  logic        mar_in;
  logic        z_in;
  logic        z_low_out;
  logic        pc_in;
  logic        read;
  logic        mdr_in;
  logic        mdr_out;
  logic        ir_in;
  logic        y_in;
  logic [3:0]  alu_op;
  logic [15:0] gpr_in;
  logic [15:0] gpr_out;

  // Status
  logic        done;
  logic        halted;

  modport master (
    input  run, ir, mem_rdy,
    output pc_out, inc_pc, mar_in, z_in, z_low_out, pc_in, read, mdr_in,
           mdr_out, ir_in, y_in, alu_op, gpr_in, gpr_out, done, halted
  );

  modport slave (
    output run, ir, mem_rdy,
    input  pc_out, inc_pc, mar_in, z_in, z_low_out, pc_in, read, mdr_in,
           mdr_out, ir_in, y_in, alu_op, gpr_in, gpr_out, done, halted
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Hardwired T0-T5 control sequencer for ezRISC register-to-register ALU instructions.
// Latency: 6 cycles per instruction (T0..T5, done in T5) plus one cycle per memory wait in T1.
// Backpressure: holds in T1 while mem_rdy is low; halts after MEM_WAIT_MAX wait cycles.
//
// Ports: clk (rising edge), reset (async, active-high), bus (alu_instr_sequencer_if.master):
//   run/ir/mem_rdy in; datapath strobes, alu_op, gpr_in/gpr_out one-hot selects, done, halted out.
// Optional feature macro: SEQ_UNARY_EN -- when defined, neg (16) and not (17) are legal
//   unary ops; otherwise they decode as illegal and halt the sequencer from T3.
module alu_instr_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_instr_sequencer_if.master bus
);

  // State encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;

  // ALU operation codes seen by the datapath
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
`ifdef SEQ_UNARY_EN
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;
`endif

  // Wait counter counts T1 cycles already spent without mem_rdy.
  localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // ------------------------------------------------------------------
  // IR field extraction and opcode decode
  // ------------------------------------------------------------------
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       op_legal;
  logic       op_unary;
  logic [3:0] op_alu;
  logic       unused_ir_bits;

  assign opcode = bus.ir[31:27];
  assign ra     = bus.ir[26:23];
  assign rb     = bus.ir[22:19];
  assign rc     = bus.ir[18:15];
  // Low IR bits carry immediates for other instruction classes.
  assign unused_ir_bits = ^bus.ir[14:0];

  always_comb begin
    op_legal = 1'b1;
    op_unary = 1'b0;
    op_alu   = ALU_AND;
    case (opcode)
      5'd3:  op_alu = ALU_ADD;
      5'd4:  op_alu = ALU_SUB;
      5'd5:  op_alu = ALU_SHR;
      5'd6:  op_alu = ALU_SHL;
      5'd7:  op_alu = ALU_ROR;
      5'd8:  op_alu = ALU_ROL;
      5'd9:  op_alu = ALU_AND;
      5'd10: op_alu = ALU_OR;
`ifdef SEQ_UNARY_EN
      5'd16: begin
        op_alu   = ALU_NEG;
        op_unary = 1'b1;
      end
      5'd17: begin
        op_alu   = ALU_NOT;
        op_unary = 1'b1;
      end
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_T0;
      end
      S_T0: begin
        state_d    = S_T1;
        wait_cnt_d = '0;
      end
      S_T1: begin
        if (bus.mem_rdy) begin
          state_d = S_T2;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // This cycle is the MEM_WAIT_MAX-th consecutive miss: abort the fetch.
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_T2: state_d = S_T3;
      // IR was loaded at the end of T2, so the decode is trustworthy here.
      S_T3: state_d = op_legal ? S_T4 : S_HALT;
      S_T4: state_d = S_T5;
      S_T5: state_d = bus.run ? S_T0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Moore output decode: state register and IR only. Because every output
  // is decoded from state_q, asserting reset zeroes them immediately.
  // ------------------------------------------------------------------
  logic        pc_out, inc_pc, mar_in, z_in, z_low_out, pc_in;
  logic        read, mdr_in, mdr_out, ir_in, y_in, done, halted;
  logic [3:0]  alu_op;
  logic [15:0] gpr_in, gpr_out;

  always_comb begin
    pc_out    = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    z_in      = 1'b0;
    z_low_out = 1'b0;
    pc_in     = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    done      = 1'b0;
    halted    = 1'b0;
    alu_op    = ALU_AND;
    gpr_in    = '0;
    gpr_out   = '0;
    case (state_q)
      S_T0: begin
        // PC -> MAR, and PC+1 into Z through the ALU.
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
        alu_op = ALU_ADD;
      end
      S_T1: begin
        // Z -> PC is repeated every wait cycle; reloading the same value is harmless.
        z_low_out = 1'b1;
        pc_in     = 1'b1;
        read      = 1'b1;
        mdr_in    = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        // Binary ops stage Rb in Y; unary and illegal ops leave T3 quiet.
        if (op_legal && !op_unary) begin
          gpr_out = 16'h0001 << rb;
          y_in    = 1'b1;
        end
      end
      S_T4: begin
        z_in    = 1'b1;
        alu_op  = op_alu;
        gpr_out = op_unary ? (16'h0001 << rb) : (16'h0001 << rc);
      end
      S_T5: begin
        z_low_out = 1'b1;
        gpr_in    = 16'h0001 << ra;
        done      = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_out    = pc_out;
  assign bus.inc_pc    = inc_pc;
  assign bus.mar_in    = mar_in;
  assign bus.z_in      = z_in;
  assign bus.z_low_out = z_low_out;
  assign bus.pc_in     = pc_in;
  assign bus.read      = read;
  assign bus.mdr_in    = mdr_in;
  assign bus.mdr_out   = mdr_out;
  assign bus.ir_in     = ir_in;
  assign bus.y_in      = y_in;
  assign bus.alu_op    = alu_op;
  assign bus.gpr_in    = gpr_in;
  assign bus.gpr_out   = gpr_out;
  assign bus.done      = done;
  assign bus.halted    = halted;

  // Register selects must never drive or load more than one GPR at once.
  a_gpr_in_onehot0:  assert property (@(posedge clk) disable iff (reset) $onehot0(gpr_in));
  a_gpr_out_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gpr_out));

endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Hardwired control sequencer for ezRISC register-to-register ALU instructions. It drives the datapath's control inputs through the fetch/execute steps T0–T5 that the datapath bench currently drives by hand: PC increment, memory fetch, IR load, Y load, ALU operation, and Z write-back. It sits directly upstream of `datapath`, with its outputs connected one-to-one to the same-named datapath ports. It reads back the datapath IR and handshakes with memory on reads.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: maximum wait cycles in T1 before the fetch is aborted and the sequencer halts.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `run` in 1: level signal; while high, the sequencer fetches and executes instructions back-to-back.
- `ir` in 32: current datapath IR contents.
- `mem_rdy` in 1: memory read data is valid on `m_data_in` this cycle.
- `pc_out`, `inc_pc`, `mar_in`, `z_in`, `z_low_out`, `pc_in`, `read`, `mdr_in`, `mdr_out`, `ir_in`, `y_in` out 1 each: datapath strobes.
- `alu_op` out 4: ALU operation. And=0, Or=1, Add=2, Sub=3, Shr=4, Shl=5, Ror=6, Rol=7, Neg=10, Not=11.
- `gpr_in` out 16, `gpr_out` out 16: one-hot register load/drive selects.
- `done` out 1: one-cycle pulse in T5.
- `halted` out 1: sticky flag for an illegal opcode or memory timeout.

## Operation
- IR fields: opcode = `ir[31:27]`, Ra = `ir[26:23]`, Rb = `ir[22:19]`, Rc = `ir[18:15]`.
- Opcode map: 3 add, 4 sub, 5 shr, 6 shl, 7 ror, 8 rol, 9 and, 10 or, 16 neg, 17 not. All other opcodes are illegal.
- Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, HALT. All outputs decode from the state register and `ir` only; none depend combinationally on `mem_rdy` or `run`.
- IDLE: all outputs 0. If `run`=1, go to T0.
- T0: `pc_out`, `mar_in`, `inc_pc`, `z_in` = 1; `alu_op`=Add. Go to T1.
- T1: `z_low_out`, `pc_in`, `read`, `mdr_in` = 1, held every cycle while waiting (PC reload is idempotent). If `mem_rdy`=1, go to T2. After `MEM_WAIT_MAX` consecutive cycles without `mem_rdy`, go to HALT.
- T2: `mdr_out`, `ir_in` = 1. Go to T3.
- T3: decode `ir`.
  - Illegal opcode: go to HALT, no strobes asserted.
  - Unary op (neg/not): T3 is skipped in effect. No strobes are asserted; go to T4.
  - Binary op: `gpr_out` = 1<<Rb, `y_in`=1. Go to T4.
- T4: `z_in`=1, `alu_op` mapped from opcode.
  - Binary op: `gpr_out` = 1<<Rc.
  - Unary op: `gpr_out` = 1<<Rb.
  - Go to T5.
- T5: `z_low_out`=1, `gpr_in` = 1<<Ra, `done`=1. If `run`=1, go to T0; otherwise go to IDLE.
- HALT: all strobes 0, `halted`=1. Exit only via `reset`.

## Timing
- Reset (asynchronous assert): state becomes IDLE, every output 0 (including `halted` and `done`) immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- Reset during any state, including a T1 wait: the in-flight instruction is abandoned and no partial write-back occurs.
- Instruction latency with `mem_rdy` high in T1: 6 cycles, T0 through T5, with `done` in the 6th cycle. Each wait cycle adds 1.
- Back-to-back: T5 is followed directly by T0 with no idle cycle.
- `run` is sampled only in IDLE and T5. Dropping `run` mid-instruction still completes the instruction.
- `ir` is treated as valid from T3 onward, after the IR load at the end of T2.

## Configuration
- `SEQ_UNARY_EN`:
  - Defined: neg (16) and not (17) are legal and execute as described in Operation.
  - Undefined: opcodes 16 and 17 are illegal and go to HALT from T3.

## Test plan
- rol R5,R2,R4 (`ir`=0x42920000), `mem_rdy`=1, `run` pulsed for 1 cycle:
  - T3: `gpr_out`=0x0004, `y_in`=1.
  - T4: `gpr_out`=0x0010, `alu_op`=7, `z_in`=1.
  - T5: `gpr_in`=0x0020, `done`=1 in cycle 6.
  - Then return to IDLE.
- Same instruction with `mem_rdy` low for 3 cycles: T1 lasts 4 cycles, `read`=`mdr_in`=1 throughout, `done` in cycle 9.
- neg R1,R3 (`ir`=0x80980000) with `SEQ_UNARY_EN` defined:
  - T3 has no strobes.
  - T4: `gpr_out`=0x0008, `alu_op`=10.
  - T5: `gpr_in`=0x0002.
- Same `ir` without `SEQ_UNARY_EN`, and separately `ir`=0x00000000 (opcode 0): `halted`=1 after T3, no `gpr_in` activity, HALT persists until `reset`.
- `mem_rdy` held low: HALT after exactly `MEM_WAIT_MAX`=15 T1 cycles.
- `reset` asserted mid-T4: all outputs 0 before the next edge, and after release the FSM is in IDLE. Separately, with `run` held high, two rol instructions complete with `done` pulses exactly 6 cycles apart.
